// File: rtl/alu_seq.sv
// Sequencing front end for the ALU/MUL/DIV datapath: a 2-entry issue queue
// feeding an execute stage that holds operands for the op's full latency.
module alu_seq #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_opcode,
    input  logic [4:0]  in_regA,
    input  logic [11:0] in_regB,
    input  logic [4:0]  in_regDest,
    input  logic        flush,
    output logic [9:0]  alu_opcode,
    output logic [4:0]  alu_regA,
    output logic [11:0] alu_regB,
    output logic [4:0]  alu_regDest,
    output logic        alu_we,
    output logic        busy,
    output logic [31:0] retired
);

    typedef struct packed {
        logic [9:0]  opcode;
        logic [4:0]  rega;
        logic [11:0] regb;
        logic [4:0]  rd;
    } op_t;

    typedef enum logic {IDLE, EXEC} state_t;

    op_t        fifo_q [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;

    state_t     state;
    logic [5:0] cnt;
    op_t        ex_op;

    op_t        head;
    logic       push;
    logic       pop;
    logic       last;

    // Execute cycles minus one, so the counter reaches 0 on the final cycle.
    function automatic logic [5:0] lat_m1(input op_t op);
        logic [6:0] op7;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       md;
        op7 = op.opcode[6:0];
        f3  = op.opcode[9:7];
        f7  = op.regb[11:5];
        md  = (op7 == 7'h33 || op7 == 7'h3B) && f7 == 7'b0000001;
        if (md && !f3[2])
            lat_m1 = 6'(MUL_LAT - 1);
        else if (md)
            lat_m1 = 6'(DIV_LAT - 1);
        else
            lat_m1 = 6'd0;
    endfunction

    assign head     = fifo_q[rd_ptr];
    assign in_ready = (count < 2'd2);
    assign push     = in_valid && in_ready && !flush;
    assign last     = (state == EXEC) && (cnt == 6'd0);
    assign pop      = !flush && (count != 2'd0) && (state == IDLE || last);
    assign alu_we   = last && (ex_op.rd != 5'd0) && !flush;
    assign busy     = (state == EXEC) || (count != 2'd0);

    assign alu_opcode  = ex_op.opcode;
    assign alu_regA    = ex_op.rega;
    assign alu_regB    = ex_op.regb;
    assign alu_regDest = ex_op.rd;

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= '{in_opcode, in_regA, in_regB, in_regDest};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            ex_op   <= '0;
            retired <= 32'd0;
        end else begin
            if (alu_we)
                retired <= retired + 32'd1;
            if (flush) begin
                state <= IDLE;
                cnt   <= 6'd0;
            end else if (pop) begin
                // Back-to-back ops reload here without an idle bubble.
                ex_op <= head;
                cnt   <= lat_m1(head);
                state <= EXEC;
            end else if (last) begin
                state <= IDLE;
            end else if (state == EXEC) begin
                cnt <= cnt - 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_seq;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_opcode = '0;
    logic [4:0]  in_regA = '0;
    logic [11:0] in_regB = '0;
    logic [4:0]  in_regDest = '0;
    logic        flush = 1'b0;
    logic [9:0]  alu_opcode;
    logic [4:0]  alu_regA;
    logic [11:0] alu_regB;
    logic [4:0]  alu_regDest;
    logic        alu_we;
    logic        busy;
    logic [31:0] retired;

    alu_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_regA(in_regA),
        .in_regB(in_regB), .in_regDest(in_regDest),
        .flush(flush),
        .alu_opcode(alu_opcode), .alu_regA(alu_regA),
        .alu_regB(alu_regB), .alu_regDest(alu_regDest),
        .alu_we(alu_we), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  opc;
        logic [4:0]  ra;
        logic [11:0] rb;
        logic [4:0]  rd;
    } top_t;

    top_t        mq[$];
    top_t        mcur;
    bit          mexec;
    int          mrem;
    int unsigned mret;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input top_t o);
        int op7;
        int f3;
        int f7;
        op7 = int'(o.opc[6:0]);
        f3  = int'(o.opc[9:7]);
        f7  = int'(o.rb[11:5]);
        if ((op7 == 'h33 || op7 == 'h3B) && f7 == 1)
            return (f3 < 4) ? MUL_LAT : DIV_LAT;
        return 1;
    endfunction

    function automatic bit exp_we(input bit fl);
        return mexec && mrem == 1 && mcur.rd != 0 && !fl;
    endfunction

    function automatic void model_reset();
        mq.delete();
        mcur  = '{default: 0};
        mexec = 0;
        mrem  = 0;
        mret  = 0;
    endfunction

    function automatic top_t mk(input logic [9:0] opc, input logic [4:0] ra,
                                input logic [11:0] rb, input logic [4:0] rd);
        top_t o;
        o.opc = opc;
        o.ra  = ra;
        o.rb  = rb;
        o.rd  = rd;
        return o;
    endfunction

    function automatic top_t rand_op();
        int   k;
        top_t o;
        k = $urandom_range(0, 7);
        o.ra = 5'($urandom);
        o.rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        if (k < 2) begin
            o.opc = {3'($urandom), 7'h13};
            o.rb  = 12'($urandom);
        end else if (k < 4) begin
            o.opc = {3'($urandom), 7'h33};
            o.rb  = {7'h00, 5'($urandom)};
        end else if (k < 6) begin
            o.opc = {3'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 7'h3B : 7'h33};
            o.rb  = {7'h01, 5'($urandom)};
        end else if (k == 6) begin
            o.opc = {3'($urandom_range(4, 7)), 7'h33};
            o.rb  = {7'h01, 5'($urandom)};
        end else begin
            o.opc = {3'($urandom), 7'h33};
            o.rb  = {7'h20, 5'($urandom)};
        end
        return o;
    endfunction

    // One clock: drive at negedge, check mid-cycle, advance the model.
    task automatic step(input bit v, input top_t o, input bit fl);
        bit we;
        bit acc;
        in_valid   = v;
        in_opcode  = o.opc;
        in_regA    = o.ra;
        in_regB    = o.rb;
        in_regDest = o.rd;
        flush      = fl;
        #1;
        check("in_ready", in_ready, mq.size() < 2);
        check("busy", busy, mexec || mq.size() > 0);
        check("alu_we", alu_we, exp_we(fl));
        check("alu_opcode", alu_opcode, mcur.opc);
        check("alu_regA", alu_regA, mcur.ra);
        check("alu_regB", alu_regB, mcur.rb);
        check("alu_regDest", alu_regDest, mcur.rd);
        check("retired", retired, mret);
        we  = exp_we(fl);
        acc = v && mq.size() < 2 && !fl;
        @(posedge clk);
        if (we)
            mret++;
        if (fl) begin
            mq.delete();
            mexec = 0;
        end else begin
            if (mexec && mrem > 1) begin
                mrem--;
            end else if (mq.size() > 0) begin
                mcur  = mq.pop_front();
                mrem  = lat_of(mcur);
                mexec = 1;
            end else begin
                mexec = 0;
            end
            if (acc)
                mq.push_back(o);
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        top_t z;
        z = '{default: 0};
        for (int i = 0; i < n; i++)
            step(0, z, 0);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_alu_we"}, alu_we, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_in_ready"}, in_ready, 1);
        check({pfx, "_retired"}, retired, 0);
        check({pfx, "_opcode"}, alu_opcode, 0);
        check({pfx, "_regA"}, alu_regA, 0);
        check({pfx, "_regB"}, alu_regB, 0);
        check({pfx, "_regDest"}, alu_regDest, 0);
    endtask

    initial begin
        top_t addi;
        top_t mul;
        top_t add;
        top_t dv;
        top_t nul;
        int unsigned saved;

        addi = mk(10'h013, 5'd1, 12'h005, 5'd2);
        mul  = mk(10'h033, 5'd1, {7'h01, 5'd3}, 5'd4);
        add  = mk(10'h033, 5'd5, {7'h00, 5'd6}, 5'd7);
        dv   = mk(10'h233, 5'd8, {7'h01, 5'd9}, 5'd10);
        nul  = mk(10'h033, 5'd3, {7'h01, 5'd4}, 5'd0);

        model_reset();
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(1, addi, 0);
        idle(4);
        check("addi_retired", retired, 1);

        step(1, mul, 0);
        step(1, add, 0);
        idle(6);
        check("mul_add_retired", retired, 3);

        step(1, dv, 0);
        step(1, addi, 0);
        step(1, add, 0);
        step(1, mul, 0);
        idle(40);
        check("div_seq_retired", retired, 6);

        saved = mret;
        step(1, nul, 0);
        idle(6);
        check("rd0_retired", retired, saved);

        saved = mret;
        step(1, dv, 0);
        step(1, add, 0);
        idle(9);
        step(0, add, 1);
        check("flush_busy", busy, 0);
        idle(6);
        check("flush_retired", retired, saved);

        step(1, mul, 0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, addi, 0);
        idle(4);
        check("postrst_retired", retired, 1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1) != 0, rand_op(), $urandom_range(0, 39) == 0);
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
